// File: rtl/seq_bit_serializer_pkg.sv
// Shared definitions for the serial chain: serializer FSM encoding, default
// word width and the detect pattern used by the downstream sequence detector.
package seq_bit_serializer_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  localparam int DEFAULT_WIDTH = 6;

  localparam logic [5:0] DETECT_PATTERN = 6'b010110;

endpackage

// File: rtl/seq_bit_holdreg.sv
// One-entry holding register with valid/ready fill and an FSM-driven drain.
// in_ready comes straight from a flop so it never depends on in_valid or bit_en.
module seq_bit_holdreg
  import seq_bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             drain,
  output logic             hold_full,
  output logic [WIDTH-1:0] hold_data
);

  logic             full_r;
  logic             ready_r;
  logic [WIDTH-1:0] data_r;
  logic             fill_s;

  assign fill_s = in_valid & ready_r;

  // Fill needs an empty entry and drain needs a full one, so they never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_r  <= 1'b0;
      ready_r <= 1'b1;
      data_r  <= {WIDTH{1'b0}};
    end else if (fill_s) begin
      full_r  <= 1'b1;
      ready_r <= 1'b0;
      data_r  <= in_data;
    end else if (drain && full_r) begin
      full_r  <= 1'b0;
      ready_r <= 1'b1;
    end
  end

  assign in_ready  = ready_r;
  assign hold_full = full_r;
  assign hold_data = data_r;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: words arrive over
// valid/ready and leave one bit per bit_en strobe on the registered line x.
module seq_bit_serializer
  import seq_bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_start,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic             x_r, x_nxt_s;
  logic             x_valid_r, x_valid_nxt_s;
  logic             word_start_r, word_start_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             hold_full_s;
  logic [WIDTH-1:0] hold_data_s;
  logic             load_s;
  logic             drain_s;
  logic             fill_s;

  seq_bit_holdreg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .drain     (drain_s),
    .hold_full (hold_full_s),
    .hold_data (hold_data_s)
  );

  assign fill_s  = in_valid & in_ready;
  assign drain_s = load_s;

  // Next-state logic: everything advances only on bit_en strobes.
  always_comb begin
    state_nxt_s      = state_r;
    shreg_nxt_s      = shreg_r;
    count_nxt_s      = count_r;
    x_nxt_s          = x_r;
    x_valid_nxt_s    = x_valid_r;
    word_start_nxt_s = word_start_r;
    load_s           = 1'b0;
    if (bit_en) begin
      case (state_r)
        ST_IDLE:  load_s = hold_full_s;
        ST_SHIFT: load_s = hold_full_s & (count_r == LAST);
        default:  load_s = 1'b0;
      endcase
      if ((state_r == ST_SHIFT) && (count_r != LAST)) begin
        // Rotate rather than zero-fill; the wrapped bit is never shown.
        if (MSB_FIRST) begin
          shreg_nxt_s = {shreg_r[WIDTH-2:0], shreg_r[WIDTH-1]};
          x_nxt_s     = shreg_r[WIDTH-2];
        end else begin
          shreg_nxt_s = {shreg_r[0], shreg_r[WIDTH-1:1]};
          x_nxt_s     = shreg_r[1];
        end
        count_nxt_s      = count_r + {{(CW-1){1'b0}}, 1'b1};
        word_start_nxt_s = 1'b0;
      end else if (load_s) begin
        state_nxt_s      = ST_SHIFT;
        shreg_nxt_s      = hold_data_s;
        x_nxt_s          = MSB_FIRST ? hold_data_s[WIDTH-1] : hold_data_s[0];
        count_nxt_s      = {CW{1'b0}};
        x_valid_nxt_s    = 1'b1;
        word_start_nxt_s = 1'b1;
      end else begin
        state_nxt_s      = ST_IDLE;
        x_nxt_s          = IDLE_BIT;
        x_valid_nxt_s    = 1'b0;
        word_start_nxt_s = 1'b0;
      end
    end else begin
      load_s = 1'b0;
    end
    busy_nxt_s = (state_nxt_s == ST_SHIFT) | fill_s | (hold_full_s & ~drain_s);
  end

  // State, shifter and registered serial outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      shreg_r      <= {WIDTH{1'b0}};
      count_r      <= {CW{1'b0}};
      x_r          <= IDLE_BIT;
      x_valid_r    <= 1'b0;
      word_start_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      shreg_r      <= shreg_nxt_s;
      count_r      <= count_nxt_s;
      x_r          <= x_nxt_s;
      x_valid_r    <= x_valid_nxt_s;
      word_start_r <= word_start_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  assign x          = x_r;
  assign x_valid    = x_valid_r;
  assign word_start = word_start_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: MSB-first and LSB-first instances share stimulus
// and are checked each cycle against a word-queue model, plus directed literals.
module tb_seq_bit_serializer;
  import seq_bit_serializer_pkg::*;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         bit_en = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic m_ready, m_x, m_xv, m_ws, m_busy;
  logic l_ready, l_x, l_xv, l_ws, l_busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model: at most one pending word, plus the word on the line and its bit index.
  logic [W-1:0] pend_q[$];
  logic [W-1:0] cur_word = '0;
  int           cur_idx = -1;
  bit           chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .bit_en(bit_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(m_ready), .x(m_x), .x_valid(m_xv), .word_start(m_ws), .busy(m_busy)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .bit_en(bit_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(l_ready), .x(l_x), .x_valid(l_xv), .word_start(l_ws), .busy(l_busy)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    bit_en   = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  // Reference model update on each edge.
  initial begin : model
    bit was_empty;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        pend_q.delete();
        cur_idx = -1;
      end else begin
        was_empty = (pend_q.size() == 0);
        if (bit_en) begin
          if (cur_idx < 0 || cur_idx == W - 1) begin
            if (pend_q.size() > 0) begin
              cur_word = pend_q.pop_front();
              cur_idx  = 0;
            end else begin
              cur_idx = -1;
            end
          end else begin
            cur_idx++;
          end
        end
        if (in_valid && was_empty) pend_q.push_back(in_data);
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic ex_m, ex_l, exv, ews, erd, eb;
      if (cur_idx < 0) begin
        ex_m = 1'b1;
        ex_l = 1'b1;
      end else begin
        ex_m = cur_word[W-1-cur_idx];
        ex_l = cur_word[cur_idx];
      end
      exv = (cur_idx >= 0);
      ews = (cur_idx == 0);
      erd = (pend_q.size() == 0);
      eb  = (cur_idx >= 0) || (pend_q.size() != 0);
      check1("cyc_msb_x", m_x, ex_m);
      check1("cyc_msb_xvalid", m_xv, exv);
      check1("cyc_msb_wstart", m_ws, ews);
      check1("cyc_msb_ready", m_ready, erd);
      check1("cyc_msb_busy", m_busy, eb);
      check1("cyc_lsb_x", l_x, ex_l);
      check1("cyc_lsb_xvalid", l_xv, exv);
      check1("cyc_lsb_wstart", l_ws, ews);
      check1("cyc_lsb_ready", l_ready, erd);
      check1("cyc_lsb_busy", l_busy, eb);
    end
  end

  initial begin : stim
    logic [W-1:0]  e_m, e_l, w1, w2;
    logic [11:0]   e12;
    logic [W-1:0]  bp[3];
    logic [17:0]   got;
    int            ng, wi, rate;
    bit            acc;

    // Reset state, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    check1("rst_x", m_x, 1'b1);
    check1("rst_xvalid", m_xv, 1'b0);
    check1("rst_wstart", m_ws, 1'b0);
    check1("rst_ready", m_ready, 1'b1);
    check1("rst_busy", m_busy, 1'b0);
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    idle(2);

    // Single word MSB first; the LSB instance sees the same word reversed.
    in_valid = 1'b1;
    in_data  = DETECT_PATTERN;
    step();
    in_valid = 1'b0;
    check1("d1_ready_full", m_ready, 1'b0);
    e_m = 6'b010110;
    e_l = 6'b011010;
    for (int i = 0; i < 6; i++) begin
      step();
      check1("d1_x", m_x, e_m[5-i]);
      check1("d1_lsb_x", l_x, e_l[5-i]);
      check1("d1_xvalid", m_xv, 1'b1);
      check1("d1_wstart", m_ws, (i == 0));
      if (i == 0) check1("d1_ready_after_drain", m_ready, 1'b1);
    end
    step();
    check1("d1_idle_x", m_x, 1'b1);
    check1("d1_idle_xvalid", m_xv, 1'b0);
    check1("d1_idle_busy", m_busy, 1'b0);
    idle(3);

    // LSB-first word.
    in_valid = 1'b1;
    in_data  = 6'b000011;
    step();
    in_valid = 1'b0;
    e_l = 6'b110000;
    e_m = 6'b000011;
    for (int i = 0; i < 6; i++) begin
      step();
      check1("lsb_x", l_x, e_l[5-i]);
      check1("lsb_msb_x", m_x, e_m[5-i]);
    end
    idle(3);

    // Back-to-back words: 12 gapless bits.
    w1 = 6'b010110;
    w2 = 6'b101001;
    e12 = 12'b010110101001;
    in_valid = 1'b1;
    in_data  = w1;
    step();
    in_data = w2;
    check1("b2b_ready_e0", m_ready, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check1("b2b_x", m_x, e12[12-k]);
      check1("b2b_xvalid", m_xv, 1'b1);
      check1("b2b_wstart", m_ws, (k == 1) || (k == 7));
      if (k == 1) check1("b2b_ready_e1", m_ready, 1'b1);
      if (k == 2) begin
        check1("b2b_ready_e2", m_ready, 1'b0);
        in_valid = 1'b0;
      end
    end
    step();
    check1("b2b_end_xvalid", m_xv, 1'b0);
    idle(3);

    // Slow bit rate: one strobe every third cycle.
    w1 = 6'b110001;
    bit_en   = 1'b0;
    in_valid = 1'b1;
    in_data  = w1;
    step();
    in_valid = 1'b0;
    for (int t = 0; t < 18; t++) begin
      bit_en = ((t % 3) == 0);
      step();
      check1("slow_x", m_x, w1[5 - t/3]);
      check1("slow_xvalid", m_xv, 1'b1);
      check1("slow_wstart", m_ws, (t < 3));
    end
    idle(4);

    // Backpressure: three words offered with in_valid held high.
    bp[0] = 6'b100111;
    bp[1] = 6'b011000;
    bp[2] = 6'b111010;
    got = '0;
    ng = 0;
    wi = 0;
    bit_en   = 1'b1;
    in_valid = 1'b1;
    in_data  = bp[0];
    for (int t = 0; t < 60 && ng < 18; t++) begin
      acc = in_valid && m_ready;
      step();
      if (acc) begin
        wi++;
        if (wi < 3) in_data = bp[wi];
        else in_valid = 1'b0;
      end
      if (m_xv) begin
        got = {got[16:0], m_x};
        ng++;
      end
    end
    in_valid = 1'b0;
    checkv("bp_bit_count", 32'(ng), 32'd18);
    checkv("bp_stream", 32'(got), 32'({bp[0], bp[1], bp[2]}));
    idle(4);

    // Reset mid-word with a second word held.
    in_valid = 1'b1;
    in_data  = 6'b010110;
    step();
    in_data = 6'b111111;
    step();
    step();
    in_valid = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    check1("mid_rst_x", m_x, 1'b1);
    check1("mid_rst_xvalid", m_xv, 1'b0);
    check1("mid_rst_ready", m_ready, 1'b1);
    check1("mid_rst_busy", m_busy, 1'b0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check1("post_rst_xvalid", m_xv, 1'b0);
      check1("post_rst_x", m_x, 1'b1);
    end

    // Randomized traffic across bit rates, with occasional resets.
    rate = 1;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 200) == 0) rate = $urandom_range(1, 4);
      bit_en   = (rate == 4) ? 1'($urandom_range(0, 1)) : ((c % rate) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = W'($urandom);
      reset    = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    idle(10);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
